// File: rtl/hdmi_generator_pkg.sv
// Shared constants for the HDMI pixel packer/unpacker pair: 8 pixels of 24 bits
// pack densely into 3 little-endian 64-bit words.
package hdmi_generator_pkg;

    localparam int PIX_BYTES    = 3;
    localparam int WORD_BYTES   = 8;
    localparam int GROUP_PIXELS = 8;
    localparam int GROUP_WORDS  = 3;
    localparam int BUF_BYTES    = WORD_BYTES + PIX_BYTES;
    localparam int LVL_W        = 4;

    // Byte offset inside its output word at which pixel pix_idx of a group starts.
    function automatic logic [LVL_W-1:0] pix_bytes_to_word_offset(input logic [2:0] pix_idx);
        int byte_pos;
        byte_pos = int'(pix_idx) * PIX_BYTES;
        return LVL_W'(byte_pos % WORD_BYTES);
    endfunction

endpackage

// File: rtl/hdmi_rgb_packer.sv
// Packs a 24-bit pixel AXI-Stream into dense 64-bit words; tlast flushes a zero-padded word.
// Optional start-of-frame handling (tuser ports, sof_drop) under HDMI_RGB_PACKER_TUSER_EN.
module hdmi_rgb_packer
    import hdmi_generator_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PIX_W  = 24
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [PIX_W-1:0]  s_axis_pix_tdata,
    input  logic              s_axis_pix_tvalid,
    input  logic              s_axis_pix_tlast,
    output logic              s_axis_pix_tready,
`ifdef HDMI_RGB_PACKER_TUSER_EN
    input  logic              s_axis_pix_tuser,
    output logic              m_axis_rgb_tuser,
    output logic              sof_drop,
`endif
    output logic [DATA_W-1:0] m_axis_rgb_tdata,
    output logic              m_axis_rgb_tvalid,
    output logic              m_axis_rgb_tlast,
    input  logic              m_axis_rgb_tready,
    output logic              frame_done
);

    localparam logic [LVL_W-1:0] LVL_WORD = LVL_W'(WORD_BYTES);
    localparam logic [LVL_W-1:0] LVL_PIX  = LVL_W'(PIX_BYTES);

    logic [BUF_BYTES*8-1:0] buf_q, buf_d;
    logic [LVL_W-1:0]       lvl_q, lvl_d;
    logic                   flush_q, flush_d;
    logic                   frame_done_q;

    logic                   m_valid;
    logic                   s_ready;
    logic                   push, pop, final_pop;
    logic [LVL_W-1:0]       base;
    logic [LVL_W+2:0]       wr_bit;
    logic [DATA_W-1:0]      word_masked;

`ifdef HDMI_RGB_PACKER_TUSER_EN
    logic                   sof_q, sof_d;
    logic                   sof_drop_q, drop;
`endif

    assign m_valid   = (lvl_q >= LVL_WORD) | (flush_q & (lvl_q != '0));
    // Ready looks straight through to downstream ready so a pop and a push share a cycle.
    assign s_ready   = ~areset & ~flush_q & ((lvl_q < LVL_WORD) | m_axis_rgb_tready);
    assign push      = s_axis_pix_tvalid & s_ready;
    assign pop       = m_valid & m_axis_rgb_tready;
    assign final_pop = pop & flush_q & (lvl_q <= LVL_WORD);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        buf_d   = buf_q;
        lvl_d   = lvl_q;
        flush_d = flush_q;
        base    = lvl_q;
`ifdef HDMI_RGB_PACKER_TUSER_EN
        sof_d   = sof_q;
        drop    = 1'b0;
        if (pop) sof_d = 1'b0;
`endif
        if (pop) begin
            buf_d = buf_q >> DATA_W;
            base  = (lvl_q >= LVL_WORD) ? lvl_q - LVL_WORD : '0;
            lvl_d = base;
            if (final_pop) begin
                buf_d   = '0;
                flush_d = 1'b0;
            end
        end
        if (push) begin
`ifdef HDMI_RGB_PACKER_TUSER_EN
            if (s_axis_pix_tuser) begin
                drop  = (lvl_q != '0) | flush_q;
                buf_d = '0;
                base  = '0;
                sof_d = 1'b1;
            end
`endif
            wr_bit = {base, 3'b000};
            buf_d[wr_bit +: PIX_W] = s_axis_pix_tdata;
            lvl_d   = base + LVL_PIX;
            flush_d = s_axis_pix_tlast;
        end else begin
            wr_bit = '0;
        end
    end

    // Bytes past the fill level of a flushed word always read as zero padding.
    always_comb begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (flush_q && (LVL_W'(b) >= lvl_q)) word_masked[b*8 +: 8] = 8'h00;
            else                                 word_masked[b*8 +: 8] = buf_q[b*8 +: 8];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            buf_q        <= '0;
            lvl_q        <= '0;
            flush_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            buf_q        <= buf_d;
            lvl_q        <= lvl_d;
            flush_q      <= flush_d;
            frame_done_q <= final_pop;
        end
    end

`ifdef HDMI_RGB_PACKER_TUSER_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sof_q      <= 1'b0;
            sof_drop_q <= 1'b0;
        end else begin
            sof_q      <= sof_d;
            sof_drop_q <= drop;
        end
    end

    assign m_axis_rgb_tuser = sof_q & m_valid;
    assign sof_drop         = sof_drop_q;
`endif

    assign s_axis_pix_tready = s_ready;
    assign m_axis_rgb_tvalid = m_valid;
    assign m_axis_rgb_tdata  = word_masked;
    assign m_axis_rgb_tlast  = flush_q & (lvl_q <= LVL_WORD) & m_valid;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_hdmi_rgb_packer.sv
// Self-checking bench for hdmi_rgb_packer: directed vector table, corner sequences and a
// randomized stream scored against a byte-queue reference model.
module tb_hdmi_rgb_packer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic        frame_done;
`ifdef HDMI_RGB_PACKER_TUSER_EN
    logic        s_tuser = 1'b0;
    logic        m_tuser;
    logic        sof_drop;
`endif

    hdmi_rgb_packer dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_axis_pix_tdata  (s_tdata),
        .s_axis_pix_tvalid (s_tvalid),
        .s_axis_pix_tlast  (s_tlast),
        .s_axis_pix_tready (s_tready),
`ifdef HDMI_RGB_PACKER_TUSER_EN
        .s_axis_pix_tuser  (s_tuser),
        .m_axis_rgb_tuser  (m_tuser),
        .sof_drop          (sof_drop),
`endif
        .m_axis_rgb_tdata  (m_tdata),
        .m_axis_rgb_tvalid (m_tvalid),
        .m_axis_rgb_tlast  (m_tlast),
        .m_axis_rgb_tready (m_tready),
        .frame_done        (frame_done)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just a byte stream cut into 8-byte words, zero-padded at the end.
    byte unsigned q_bytes[$];
    bit           closed = 1'b0;
    bit           exp_sof = 1'b0;
    bit           exp_drop = 1'b0;
    bit           stall_prev = 1'b0;
    logic [63:0]  stall_data;
    logic         stall_last;
    int           words_in_frame = 0;
    int           last_frame_words = 0;
    logic [63:0]  last_word = '0;
    int           fd_count = 0;
    int           frames_sent = 0;

    always @(negedge aclk) begin
        int          pre_size;
        logic [63:0] exp_w;
        logic        exp_l;
        if (areset) begin
            q_bytes.delete();
            closed         = 1'b0;
            stall_prev     = 1'b0;
            words_in_frame = 0;
            exp_sof        = 1'b0;
            exp_drop       = 1'b0;
        end else begin
            pre_size = q_bytes.size();
            if (frame_done) fd_count++;
            check("m_tvalid", m_tvalid, (pre_size >= 8) || (closed && pre_size > 0));
            check("s_tready", s_tready, !closed && (pre_size < 8 || m_tready));
`ifdef HDMI_RGB_PACKER_TUSER_EN
            check("sof_drop", sof_drop, exp_drop);
            exp_drop = 1'b0;
`endif
            if (stall_prev) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_data", m_tdata, stall_data);
                check("hold_last", m_tlast, stall_last);
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;

            if (m_tvalid && m_tready) begin
                exp_w = '0;
                for (int b = 0; b < 8; b++)
                    if (q_bytes.size() > 0) exp_w[b*8 +: 8] = q_bytes.pop_front();
                exp_l = closed && (q_bytes.size() == 0);
                check("word_data", m_tdata, exp_w);
                check("word_last", m_tlast, exp_l);
`ifdef HDMI_RGB_PACKER_TUSER_EN
                check("word_tuser", m_tuser, exp_sof);
                exp_sof = 1'b0;
`endif
                words_in_frame++;
                last_word = m_tdata;
                if (exp_l) begin
                    closed           = 1'b0;
                    last_frame_words = words_in_frame;
                    words_in_frame   = 0;
                end
            end

            if (s_tvalid && s_tready) begin
`ifdef HDMI_RGB_PACKER_TUSER_EN
                if (s_tuser) begin
                    exp_drop = (pre_size > 0);
                    q_bytes.delete();
                    words_in_frame = 0;
                    exp_sof = 1'b1;
                end
`endif
                for (int b = 0; b < 3; b++) q_bytes.push_back(s_tdata[b*8 +: 8]);
                if (s_tlast) closed = 1'b1;
            end
        end
    end

    typedef struct {
        logic [23:0] data;
        logic        last;
        logic        user;
    } pix_t;

    pix_t tx_q[$];

    task automatic queue_pix(input logic [23:0] data, input logic last, input logic user);
        pix_t p;
        p.data = data;
        p.last = last;
        p.user = user;
        tx_q.push_back(p);
        if (last) frames_sent++;
    endtask

    // rdy_mode: 0 always ready, 1 toggle, 2 random, 3 never ready.
    task automatic run_tx(input int rdy_mode, input int gap_pct);
        int   budget = 4000;
        bit   have = 1'b0;
        bit   acc = 1'b0;
        pix_t cur;
        @(posedge aclk); #1;
        while ((tx_q.size() > 0 || have) && budget > 0) begin
            if (have && acc) have = 1'b0;
            if (!have && tx_q.size() > 0 && ($urandom_range(99) >= gap_pct)) begin
                cur  = tx_q.pop_front();
                have = 1'b1;
            end
            s_tvalid = have;
            s_tdata  = have ? cur.data : 24'h0;
            s_tlast  = have ? cur.last : 1'b0;
`ifdef HDMI_RGB_PACKER_TUSER_EN
            s_tuser  = have ? cur.user : 1'b0;
`endif
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                2:       m_tready = ($urandom_range(2) != 0);
                default: m_tready = 1'b0;
            endcase
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk); #1;
            budget--;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
`ifdef HDMI_RGB_PACKER_TUSER_EN
        s_tuser  = 1'b0;
`endif
        check("tx_budget", budget > 0, 1'b1);
    endtask

    task automatic drain();
        int budget = 300;
        m_tready = 1'b1;
        while ((q_bytes.size() > 0 || closed) && budget > 0) begin
            @(posedge aclk); #1;
            budget--;
        end
        check("drain_budget", budget > 0, 1'b1);
        @(posedge aclk); #1;
    endtask

    typedef struct {
        logic [23:0] pix;
        logic        last;
        logic        exp_v;
        logic [63:0] exp_w;
        logic        exp_l;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{24'h000001, 1'b0, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{24'h000002, 1'b0, 1'b0, 64'h0, 1'b0};
        tbl[2] = '{24'h000003, 1'b0, 1'b1, 64'h0003000002000001, 1'b0};
        tbl[3] = '{24'h000004, 1'b0, 1'b0, 64'h0, 1'b0};
        tbl[4] = '{24'h000005, 1'b0, 1'b0, 64'h0, 1'b0};
        tbl[5] = '{24'h000006, 1'b0, 1'b1, 64'h0600000500000400, 1'b0};
        tbl[6] = '{24'h000007, 1'b0, 1'b0, 64'h0, 1'b0};
        tbl[7] = '{24'h000008, 1'b1, 1'b1, 64'h0000080000070000, 1'b1};

        // Reset state, before any clock edge.
        #2;
        check("rst_tready", s_tready, 1'b0);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, 64'h0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;

        // Full group at full rate: exact cycle timing from the vector table.
        m_tready = 1'b1;
        frames_sent++;
        @(posedge aclk); #1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                s_tvalid = 1'b1;
                s_tdata  = tbl[i].pix;
                s_tlast  = tbl[i].last;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            @(negedge aclk);
            if (i < 8) check("t1_no_bubble", s_tready, 1'b1);
            if (i > 0) begin
                check("t1_valid", m_tvalid, tbl[i-1].exp_v);
                if (tbl[i-1].exp_v) begin
                    check("t1_data", m_tdata, tbl[i-1].exp_w);
                    check("t1_last", m_tlast, tbl[i-1].exp_l);
                end
            end
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("t1_frame_done", frame_done, 1'b1);
        check("t1_idle_valid", m_tvalid, 1'b0);
        @(negedge aclk);
        check("t1_frame_done_pulse", frame_done, 1'b0);

        // Same group with downstream ready toggling every cycle.
        for (int i = 0; i < 8; i++) queue_pix(24'(i + 1), i == 7, 1'b0);
        run_tx(1, 0);
        drain();
        check("t2_words", last_frame_words, 3);
        check("t2_last_word", last_word, 64'h0000080000070000);

        // One-pixel frame held by a stalled downstream.
        queue_pix(24'hABCDEF, 1'b1, 1'b0);
        run_tx(3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("t3_tready_low", s_tready, 1'b0);
            check("t3_valid", m_tvalid, 1'b1);
            check("t3_data", m_tdata, 64'h0000000000ABCDEF);
            check("t3_last", m_tlast, 1'b1);
        end
        @(posedge aclk); #1;
        drain();
        check("t3_words", last_frame_words, 1);

        // Eleven pixels: 33 bytes -> five words, the last holding only p10[23:16].
        for (int i = 0; i < 11; i++) queue_pix(24'h100000 + 24'(i), i == 10, 1'b0);
        run_tx(2, 20);
        drain();
        check("t4_words", last_frame_words, 5);
        check("t4_last_word", last_word, 64'h0000000000000010);
        queue_pix(24'h123456, 1'b1, 1'b0);
        run_tx(0, 0);
        drain();
        check("t4_restart_word", last_word, 64'h0000000000123456);
        check("t4_restart_words", last_frame_words, 1);

        // Asynchronous reset with five bytes buffered and downstream stalled.
        for (int i = 0; i < 7; i++) queue_pix(24'h200001 + 24'(i), 1'b0, 1'b0);
        run_tx(0, 0);
        m_tready = 1'b0;
        check("t5_pre_reset_data", m_tdata, 64'h0000002000072000);
        #2;
        areset = 1'b1;
        #1;
        check("t5_rst_tdata", m_tdata, 64'h0);
        check("t5_rst_tvalid", m_tvalid, 1'b0);
        check("t5_rst_tready", s_tready, 1'b0);
        check("t5_rst_tlast", m_tlast, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("t5_post_rst_tready", s_tready, 1'b1);
        for (int i = 0; i < 3; i++) queue_pix(24'h300001 + 24'(i), i == 2, 1'b0);
        run_tx(0, 0);
        drain();
        check("t5_words", last_frame_words, 2);
        check("t5_last_word", last_word, 64'h0000000000000030);

`ifdef HDMI_RGB_PACKER_TUSER_EN
        // Start-of-frame mid-word drops the partial frame and restarts at byte 0.
        for (int i = 0; i < 4; i++) queue_pix(24'h400001 + 24'(i), 1'b0, i == 0);
        queue_pix(24'h4A0000, 1'b0, 1'b1);
        queue_pix(24'h4B0000, 1'b1, 1'b0);
        run_tx(0, 0);
        drain();
        check("t7_words", last_frame_words, 1);
        check("t7_last_word", last_word, 64'h00004B00004A0000);
`endif

        // Randomized frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(20, 1);
            for (int i = 0; i < len; i++) queue_pix(24'($urandom), i == len - 1, 1'b0);
        end
        run_tx(2, 30);
        drain();

        repeat (3) @(negedge aclk);
        check("frame_done_count", fd_count, frames_sent);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
